// File: rtl/claw_motion_ctrl.sv
// Two-axis claw gantry sequencer. Handles homing, absolute step tracking,
// soft and hard travel limits, and a guard against instant direction reversal.
module claw_motion_ctrl #(
  parameter int POS_W        = 12,
  parameter int MAX_POS      = 2000,
  parameter int HOME_TIMEOUT = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_tick,
  input  logic             home_req,
  input  logic [3:0]       jog,
  input  logic [1:0]       limit_sw,
  output logic             x_en,
  output logic             x_dir,
  output logic             y_en,
  output logic             y_dir,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             homed,
  output logic             busy,
  output logic             fault
);

  localparam int CNT_W = $clog2(HOME_TIMEOUT + 1);
  localparam logic [POS_W-1:0] MAX_POS_V = POS_W'(MAX_POS);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(HOME_TIMEOUT);

  typedef enum logic [2:0] {UNHOMED, HOME_X, HOME_Y, READY, FAULT} state_e;

  // pend marks a reversal that is waiting for the next step tick.
  typedef struct packed {
    logic             en;
    logic             dir;
    logic             pend;
    logic [POS_W-1:0] pos;
  } axis_t;

  state_e           state_q, state_d;
  axis_t            x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             homed_q, homed_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             start_home;

  function automatic logic [POS_W-1:0] stepPos(input axis_t a, input logic tick);
    stepPos = a.pos;
    if (tick && a.en) begin
      if (a.dir) begin
        if (a.pos < MAX_POS_V) stepPos = a.pos + POS_W'(1);
      end else if (a.pos != '0) begin
        stepPos = a.pos - POS_W'(1);
      end
    end
  endfunction

  function automatic axis_t jogAxis(input axis_t a, input logic plus_b, input logic minus_b,
                                    input logic lim, input logic tick);
    axis_t n;
    logic  req_plus, req_minus, req, req_dir, at_edge;
    n         = a;
    n.pos     = stepPos(a, tick);
    req_plus  = plus_b && !minus_b && (a.pos < MAX_POS_V);
    req_minus = minus_b && !plus_b && (a.pos != '0) && !lim;
    req       = req_plus || req_minus;
    req_dir   = req_plus;
    at_edge   = tick && a.en && (a.dir ? (n.pos == MAX_POS_V) : (n.pos == '0));
    // Hard limit beats any coincident tick; soft limit beats a held jog.
    if (lim && a.en && !a.dir) begin
      n.pos  = '0;
      n.en   = 1'b0;
      n.pend = 1'b0;
    end else if (at_edge || !req) begin
      n.en   = 1'b0;
      n.pend = 1'b0;
    end else if (a.pend) begin
      if (req_dir == a.dir) begin
        n.en   = 1'b1;
        n.pend = 1'b0;
      end else if (tick) begin
        n.dir  = req_dir;
        n.en   = 1'b1;
        n.pend = 1'b0;
      end else begin
        n.en = 1'b0;
      end
    end else if (a.en && (req_dir != a.dir)) begin
      n.en   = 1'b0;
      n.pend = 1'b1;
    end else begin
      n.en  = 1'b1;
      n.dir = req_dir;
    end
    return n;
  endfunction

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    homed_d    = homed_q;
    start_home = 1'b0;
    x_d.pos    = stepPos(x_q, step_tick);
    y_d.pos    = stepPos(y_q, step_tick);

    case (state_q)
      UNHOMED: begin
        start_home = home_req;
      end
      HOME_X: begin
        if (step_tick) cnt_d = cnt_q + CNT_W'(1);
        if (limit_sw[0]) begin
          x_d.pos = '0;
          x_d.en  = 1'b0;
          y_d.en  = 1'b1;
          y_d.dir = 1'b0;
          cnt_d   = '0;
          state_d = HOME_Y;
        end else if (cnt_d == TIMEOUT_V) begin
          x_d.en  = 1'b0;
          state_d = FAULT;
        end
      end
      HOME_Y: begin
        if (step_tick) cnt_d = cnt_q + CNT_W'(1);
        if (limit_sw[1]) begin
          y_d.pos = '0;
          y_d.en  = 1'b0;
          homed_d = 1'b1;
          state_d = READY;
        end else if (cnt_d == TIMEOUT_V) begin
          y_d.en  = 1'b0;
          state_d = FAULT;
        end
      end
      READY: begin
        if (home_req) begin
          start_home = 1'b1;
        end else begin
          x_d = jogAxis(x_q, jog[0], jog[1], limit_sw[0], step_tick);
          y_d = jogAxis(y_q, jog[2], jog[3], limit_sw[1], step_tick);
        end
      end
      FAULT: begin
        x_d.pos    = x_q.pos;
        y_d.pos    = y_q.pos;
        x_d.en     = 1'b0;
        y_d.en     = 1'b0;
        start_home = home_req;
      end
      default: state_d = UNHOMED;
    endcase

    if (start_home) begin
      state_d  = HOME_X;
      cnt_d    = '0;
      homed_d  = 1'b0;
      x_d.en   = 1'b1;
      x_d.dir  = 1'b0;
      x_d.pend = 1'b0;
      y_d.en   = 1'b0;
      y_d.pend = 1'b0;
    end

    busy_d  = (state_d == HOME_X) || (state_d == HOME_Y);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNHOMED;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      homed_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      homed_q <= homed_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign x_en  = x_q.en;
  assign x_dir = x_q.dir;
  assign y_en  = y_q.en;
  assign y_dir = y_q.dir;
  assign x_pos = x_q.pos;
  assign y_pos = y_q.pos;
  assign homed = homed_q;
  assign busy  = busy_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_claw_motion_ctrl.sv
// Directed bench for claw_motion_ctrl: a homing vector table followed by
// hand-written long sequences for timeout, soft/hard limits, reversal and reset.
module tb_claw_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_tick = 1'b0;
  logic        home_req = 1'b0;
  logic [3:0]  jog = '0;
  logic [1:0]  limit_sw = '0;
  logic        x_en, x_dir, y_en, y_dir;
  logic [11:0] x_pos, y_pos;
  logic        homed, busy, fault;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        xEn;
    logic        xDir;
    logic        yEn;
    logic        yDir;
    logic [11:0] xPos;
    logic [11:0] yPos;
    logic        homed;
    logic        busy;
    logic        fault;
  } exp_t;

  typedef struct {
    string      name;
    logic       tick;
    logic       hreq;
    logic [3:0] jogV;
    logic [1:0] limV;
    exp_t       e;
  } vec_t;

  vec_t vecs[16];

  claw_motion_ctrl #(.POS_W(12), .MAX_POS(2000), .HOME_TIMEOUT(4000)) dut (
    .clk(clk), .rst(rst), .step_tick(step_tick), .home_req(home_req),
    .jog(jog), .limit_sw(limit_sw),
    .x_en(x_en), .x_dir(x_dir), .y_en(y_en), .y_dir(y_dir),
    .x_pos(x_pos), .y_pos(y_pos), .homed(homed), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic xe, input logic xd, input logic ye, input logic yd,
                              input int xp, input int yp,
                              input logic h, input logic b, input logic f);
    mk = '{xEn: xe, xDir: xd, yEn: ye, yDir: yd, xPos: 12'(xp), yPos: 12'(yp),
           homed: h, busy: b, fault: f};
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a = '{xEn: x_en, xDir: x_dir, yEn: y_en, yDir: y_dir, xPos: x_pos, yPos: y_pos,
          homed: homed, busy: busy, fault: fault};
    testsRun++;
    if (a !== e) begin
      testsFailed++;
      $display("[TB] FAIL %s: got xen/dir=%b%b yen/dir=%b%b xpos=%0d ypos=%0d h/b/f=%b%b%b, want xen/dir=%b%b yen/dir=%b%b xpos=%0d ypos=%0d h/b/f=%b%b%b",
               name, a.xEn, a.xDir, a.yEn, a.yDir, a.xPos, a.yPos, a.homed, a.busy, a.fault,
               e.xEn, e.xDir, e.yEn, e.yDir, e.xPos, e.yPos, e.homed, e.busy, e.fault);
    end
  endtask

  // Drive one cycle of inputs, sample 1ns after the edge, then drop the pulses.
  task automatic applyStimulus(input logic t, input logic h, input logic [3:0] j, input logic [1:0] l);
    @(negedge clk);
    step_tick = t;
    home_req  = h;
    jog       = j;
    limit_sw  = l;
    @(posedge clk);
    #1;
    step_tick = 1'b0;
    home_req  = 1'b0;
  endtask

  task automatic runTicks(input int n, input logic [3:0] j, input logic [1:0] l);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, j, l);
  endtask

  initial begin
    vecs[0]  = '{"unhomed jog ignored", 1'b0, 1'b0, 4'b0001, 2'b00, mk(0,0,0,0,0,0,0,0,0)};
    vecs[1]  = '{"home req",            1'b0, 1'b1, 4'b0000, 2'b00, mk(1,0,0,0,0,0,0,1,0)};
    vecs[2]  = '{"homeX tick1",         1'b1, 1'b0, 4'b0000, 2'b00, mk(1,0,0,0,0,0,0,1,0)};
    vecs[3]  = '{"homeX tick2",         1'b1, 1'b0, 4'b0000, 2'b00, mk(1,0,0,0,0,0,0,1,0)};
    vecs[4]  = '{"homeX tick3",         1'b1, 1'b0, 4'b0000, 2'b00, mk(1,0,0,0,0,0,0,1,0)};
    vecs[5]  = '{"homeX tick4",         1'b1, 1'b0, 4'b0000, 2'b00, mk(1,0,0,0,0,0,0,1,0)};
    vecs[6]  = '{"homeX tick5",         1'b1, 1'b0, 4'b0000, 2'b00, mk(1,0,0,0,0,0,0,1,0)};
    vecs[7]  = '{"x switch",            1'b0, 1'b0, 4'b0000, 2'b01, mk(0,0,1,0,0,0,0,1,0)};
    vecs[8]  = '{"homeY tick1",         1'b1, 1'b0, 4'b0000, 2'b01, mk(0,0,1,0,0,0,0,1,0)};
    vecs[9]  = '{"homeY req ignored",   1'b1, 1'b1, 4'b0000, 2'b01, mk(0,0,1,0,0,0,0,1,0)};
    vecs[10] = '{"homeY tick3",         1'b1, 1'b0, 4'b0000, 2'b01, mk(0,0,1,0,0,0,0,1,0)};
    vecs[11] = '{"y switch",            1'b0, 1'b0, 4'b0000, 2'b11, mk(0,0,0,0,0,0,1,0,0)};
    vecs[12] = '{"ready idle",          1'b0, 1'b0, 4'b0000, 2'b00, mk(0,0,0,0,0,0,1,0,0)};
    vecs[13] = '{"x- at zero",          1'b0, 1'b0, 4'b0010, 2'b00, mk(0,0,0,0,0,0,1,0,0)};
    vecs[14] = '{"y- at zero tick",     1'b1, 1'b0, 4'b1000, 2'b00, mk(0,0,0,0,0,0,1,0,0)};
    vecs[15] = '{"y both bits",         1'b0, 1'b0, 4'b1100, 2'b00, mk(0,0,0,0,0,0,1,0,0)};

    #12;
    checkOutput("reset state", mk(0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].tick, vecs[i].hreq, vecs[i].jogV, vecs[i].limV);
      checkOutput(vecs[i].name, vecs[i].e);
    end

    // Homing timeout: x switch never closes.
    applyStimulus(1'b0, 1'b1, 4'b0000, 2'b00);
    checkOutput("rehome start", mk(1,0,0,0,0,0,0,1,0));
    runTicks(3999, 4'b0000, 2'b00);
    checkOutput("before timeout", mk(1,0,0,0,0,0,0,1,0));
    runTicks(1, 4'b0000, 2'b00);
    checkOutput("timeout fault", mk(0,0,0,0,0,0,0,0,1));
    runTicks(1, 4'b0001, 2'b00);
    checkOutput("fault holds", mk(0,0,0,0,0,0,0,0,1));
    applyStimulus(1'b0, 1'b1, 4'b0000, 2'b00);
    checkOutput("fault cleared", mk(1,0,0,0,0,0,0,1,0));
    applyStimulus(1'b0, 1'b0, 4'b0000, 2'b01);
    applyStimulus(1'b0, 1'b0, 4'b0000, 2'b11);
    checkOutput("rehomed", mk(0,0,0,0,0,0,1,0,0));

    // Jog + and the soft upper limit.
    applyStimulus(1'b0, 1'b0, 4'b0001, 2'b00);
    checkOutput("x+ start", mk(1,1,0,0,0,0,1,0,0));
    runTicks(10, 4'b0001, 2'b00);
    checkOutput("x+ 10 ticks", mk(1,1,0,0,10,0,1,0,0));
    applyStimulus(1'b0, 1'b0, 4'b0011, 2'b00);
    checkOutput("x both bits", mk(0,1,0,0,10,0,1,0,0));
    runTicks(1, 4'b0011, 2'b00);
    checkOutput("x both hold", mk(0,1,0,0,10,0,1,0,0));
    applyStimulus(1'b0, 1'b0, 4'b0001, 2'b00);
    runTicks(1989, 4'b0001, 2'b00);
    checkOutput("x at 1999", mk(1,1,0,0,1999,0,1,0,0));
    runTicks(1, 4'b0001, 2'b00);
    checkOutput("x at max", mk(0,1,0,0,2000,0,1,0,0));
    runTicks(2, 4'b0001, 2'b00);
    checkOutput("x max hold", mk(0,1,0,0,2000,0,1,0,0));

    // Back down to 50, then reversal guard.
    applyStimulus(1'b0, 1'b0, 4'b0010, 2'b00);
    checkOutput("x- start", mk(1,0,0,0,2000,0,1,0,0));
    runTicks(1950, 4'b0010, 2'b00);
    checkOutput("x down to 50", mk(1,0,0,0,50,0,1,0,0));
    applyStimulus(1'b0, 1'b0, 4'b0000, 2'b00);
    applyStimulus(1'b0, 1'b0, 4'b0001, 2'b00);
    checkOutput("x+ at 50", mk(1,1,0,0,50,0,1,0,0));
    applyStimulus(1'b0, 1'b0, 4'b0010, 2'b00);
    checkOutput("reverse guard", mk(0,1,0,0,50,0,1,0,0));
    applyStimulus(1'b0, 1'b0, 4'b0010, 2'b00);
    checkOutput("reverse wait", mk(0,1,0,0,50,0,1,0,0));
    runTicks(1, 4'b0010, 2'b00);
    checkOutput("reverse flip", mk(1,0,0,0,50,0,1,0,0));
    runTicks(1, 4'b0010, 2'b00);
    checkOutput("x- after flip", mk(1,0,0,0,49,0,1,0,0));
    runTicks(19, 4'b0010, 2'b00);
    checkOutput("x down to 30", mk(1,0,0,0,30,0,1,0,0));

    // Hard limit while moving minus.
    applyStimulus(1'b0, 1'b0, 4'b0010, 2'b01);
    checkOutput("hard limit", mk(0,0,0,0,0,0,1,0,0));
    runTicks(1, 4'b0010, 2'b00);
    checkOutput("x- blocked at zero", mk(0,0,0,0,0,0,1,0,0));

    // Asynchronous reset mid-move on y.
    applyStimulus(1'b0, 1'b0, 4'b0100, 2'b00);
    runTicks(3, 4'b0100, 2'b00);
    checkOutput("y+ 3 ticks", mk(0,0,1,1,0,3,1,0,0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("async reset", mk(0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    checkOutput("reset held", mk(0,0,0,0,0,0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/claw_motion_ctrl.md
Name: claw_motion_ctrl

Overview:
Two-axis motion sequencer for the claw gantry. It sits between the debounced jog buttons/limit switches and the two stepper step-drivers, producing each driver's en/dir. It runs a homing sequence, tracks absolute step position per axis using a step-tick strobe, and enforces soft and hard travel limits. It also guards against instantaneous direction reversal.

Parameters:
POS_W, 12, width of each position counter
MAX_POS, 2000, soft upper travel limit in steps (must be < 2**POS_W)
HOME_TIMEOUT, 4000, max step ticks allowed per axis during homing before fault

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
step_tick  in  1  one-clk pulse per motor step period (synchronous to clk)
home_req  in  1  one-clk pulse: start/restart homing
jog  in  4  debounced level requests: [0] x+, [1] x-, [2] y+, [3] y-
limit_sw  in  2  home switches, high at position 0: [0] x, [1] y
x_en, x_dir  out  1 each  x driver enable / direction (1 = +)
y_en, y_dir  out  1 each  y driver enable / direction
x_pos, y_pos  out  POS_W each  current absolute position in steps
homed  out  1  high once homing has completed successfully
busy  out  1  high in HOME_X or HOME_Y
fault  out  1  high in FAULT

Behaviour:
- Reset (rst=0, async): state UNHOMED; all en/dir=0; pos=0; homed=busy=fault=0. Reset mid-move stops both axes immediately.
- All outputs are registered. An input change is reflected on the outputs at the next clk edge (1-cycle latency).
- States: UNHOMED, HOME_X, HOME_Y, READY, FAULT.
- UNHOMED:
  - jog ignored; en=0.
  - home_req -> HOME_X.
- HOME_X:
  - x_en=1, x_dir=0; y_en=0; tick counter cleared on entry.
  - Each step_tick increments the counter.
  - limit_sw[0]=1 -> x_pos=0, x_en=0, go to HOME_Y.
  - Counter reaching HOME_TIMEOUT with switch still low -> FAULT.
- HOME_Y:
  - Same as HOME_X using the y signals and limit_sw[1]; on success -> READY, homed=1.
- A switch already high on entry completes that axis on the next cycle with no motion.
- home_req while busy is ignored. home_req in READY or FAULT -> HOME_X, homed=0, fault cleared.
- FAULT: all en=0; positions hold; only home_req or reset leaves.
- READY, per axis independently:
  - Request +: the + jog bit alone and pos < MAX_POS.
  - Request -: the - jog bit alone, pos > 0, and the axis limit switch low.
  - Both bits or neither -> no request.
  - No request -> en=0 next cycle.
  - Request in the current dir, or en=0 -> en=1 and dir set to the request.
  - Reversal guard: a request opposite to the current dir while en=1 -> en=0, dir held. dir flips and en=1 only on the cycle after the next step_tick.
- Position update (all states except FAULT):
  - On step_tick with an axis en=1: pos+1 if dir=1, else pos-1.
  - pos saturates at 0 and MAX_POS and never wraps.
  - A tick that makes pos equal MAX_POS (moving +) or 0 (moving -) drops en on the next cycle, even if the jog is still held.
- Hard limit: limit_sw high while that axis moves - in READY forces pos=0 and en=0 that cycle. limit_sw high while moving + is ignored.
- step_tick coincident with a limit event: the limit wins (pos=0).
- Events coincident with home_req: home_req takes priority over jog and limit handling in READY.

Test Plan:
- Reset, then home_req with x switch asserted after 5 ticks and y after 3 -> x_en=1/x_dir=0 for 5 ticks, then y_en=1 for 3 ticks; x_pos=y_pos=0; homed=1; busy=0.
- Homing with limit_sw[0] stuck low -> fault=1 after exactly 4000 ticks; all en=0; a later home_req clears fault and restarts HOME_X.
- READY, hold jog[0] for 10 ticks -> x_en=1, x_dir=1, x_pos=10. Then jog[0]+jog[1] together -> x_en=0 next cycle; x_pos holds at 10.
- x_pos=1999, jog[0] held -> one tick gives x_pos=2000, then x_en=0 and stays 0 while jog held. jog[1] at x_pos=0 -> x_en stays 0.
- Reversal: moving + at x_pos=50, switch to jog[1] -> x_en=0 with x_dir=1 until the next tick (x_pos stays 50), then x_dir=0, x_en=1; subsequent ticks decrement.
- Moving - at x_pos=30, limit_sw[0] pulses high -> x_pos=0 and x_en=0 next cycle. Assert rst low mid-move -> all outputs 0 immediately, homed=0.
